// File: rtl/cpu_controller.sv
// Controller FSM: sequences fetch through the PC/IR chain and decodes each instruction
// into register-file, ALU and data-memory control. Outputs are decoded from state and IR.
module cpu_controller (
  input  logic        Clock,
  input  logic        Clr_n,
  input  logic [15:0] IR,
  input  logic        RF_Rp_zero,
  output logic        PC_clr,
  output logic        PC_up,
  output logic        PC_ld,
  output logic [7:0]  PC_off,
  output logic        IR_ld,
  output logic [7:0]  D_addr,
  output logic        D_rd,
  output logic        D_wr,
  output logic [1:0]  RF_s,
  output logic [7:0]  RF_W_data,
  output logic [3:0]  RF_W_addr,
  output logic        RF_W_wr,
  output logic [3:0]  RF_Rp_addr,
  output logic [3:0]  RF_Rq_addr,
  output logic        RF_Rp_rd,
  output logic        RF_Rq_rd,
  output logic [1:0]  alu_s,
  output logic        halted
);

  typedef enum logic [3:0] {
    S_INIT, S_WAIT, S_FETCH, S_DECODE, S_LOAD1, S_LOAD2, S_STORE,
    S_ADD, S_SUB, S_LDC, S_JZ, S_JZ_TAKE, S_HALT
  } state_t;

  state_t state_q, state_d;

  logic [3:0] opcode, ra, rb, rc;
  logic [7:0] imm8;

  assign opcode = IR[15:12];
  assign ra     = IR[11:8];
  assign rb     = IR[7:4];
  assign rc     = IR[3:0];
  assign imm8   = IR[7:0];

  always_ff @(posedge Clock or negedge Clr_n) begin
    if (!Clr_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  // Unused encodings fall through to INIT so a corrupted state restarts fetch.
  always_comb begin
    state_d = S_INIT;
    case (state_q)
      S_INIT:    state_d = S_WAIT;
      S_WAIT:    state_d = S_FETCH;
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          4'h0:    state_d = S_LOAD1;
          4'h1:    state_d = S_STORE;
          4'h2:    state_d = S_ADD;
          4'h3:    state_d = S_LDC;
          4'h4:    state_d = S_SUB;
          4'h5:    state_d = S_JZ;
          default: state_d = S_HALT;
        endcase
      end
      S_LOAD1:   state_d = S_LOAD2;
      S_LOAD2:   state_d = S_WAIT;
      S_STORE:   state_d = S_WAIT;
      S_ADD:     state_d = S_WAIT;
      S_SUB:     state_d = S_WAIT;
      S_LDC:     state_d = S_WAIT;
      S_JZ:      state_d = RF_Rp_zero ? S_JZ_TAKE : S_WAIT;
      S_JZ_TAKE: state_d = S_WAIT;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_INIT;
    endcase
  end

  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    PC_ld      = 1'b0;
    PC_off     = 8'h00;
    IR_ld      = 1'b0;
    D_addr     = 8'h00;
    D_rd       = 1'b0;
    D_wr       = 1'b0;
    RF_s       = 2'b00;
    RF_W_data  = 8'h00;
    RF_W_addr  = 4'h0;
    RF_W_wr    = 1'b0;
    RF_Rp_addr = 4'h0;
    RF_Rq_addr = 4'h0;
    RF_Rp_rd   = 1'b0;
    RF_Rq_rd   = 1'b0;
    alu_s      = 2'b00;
    halted     = 1'b0;
    case (state_q)
      S_INIT:  PC_clr = 1'b1;
      S_FETCH: begin
        IR_ld = 1'b1;
        PC_up = 1'b1;
      end
      S_LOAD1: begin
        D_addr = imm8;
        D_rd   = 1'b1;
      end
      S_LOAD2: begin
        D_addr    = imm8;
        D_rd      = 1'b1;
        RF_s      = 2'b01;
        RF_W_addr = ra;
        RF_W_wr   = 1'b1;
      end
      S_STORE: begin
        D_addr     = imm8;
        D_wr       = 1'b1;
        RF_Rp_addr = ra;
        RF_Rp_rd   = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Rp_addr = rb;
        RF_Rq_addr = rc;
        RF_Rp_rd   = 1'b1;
        RF_Rq_rd   = 1'b1;
        alu_s      = (state_q == S_ADD) ? 2'b01 : 2'b10;
        RF_s       = 2'b00;
        RF_W_addr  = ra;
        RF_W_wr    = 1'b1;
      end
      S_LDC: begin
        RF_s      = 2'b10;
        RF_W_data = imm8;
        RF_W_addr = ra;
        RF_W_wr   = 1'b1;
      end
      S_JZ: begin
        RF_Rp_addr = ra;
        RF_Rp_rd   = 1'b1;
      end
      S_JZ_TAKE: begin
        PC_ld  = 1'b1;
        PC_off = imm8;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule
